// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for a multicycle MIPS datapath that
// shares one memory for instructions and data. It decodes op/func from the IR,
// drives every datapath strobe and mux select, and waits on mem_ready. It also
// counts retired instructions and halts on an illegal opcode or a memory stall
// that lasts too long.
module multicycle_control #(
    parameter int CNT_W   = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_cntl,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        I_EXEC   = 4'd9,
        I_WB     = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd15
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Wider than the counter so TIMEOUT == 2^TO_W cannot wrap the compare.
    localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT);

    state_t          st, st_nxt;
    logic [TO_W-1:0] wcnt;
    logic            in_mem;
    logic            to_hit;
    logic            r_legal;
    logic [3:0]      r_alu;

    // A memory state is one that can stall on mem_ready.
    assign in_mem = (st == FETCH) || (st == MEM_RD) || (st == MEM_WR);

    // Limit fires on the wait cycle that brings the count to TIMEOUT;
    // mem_ready on that same cycle takes priority in the next-state logic.
    assign to_hit = (TIMEOUT != 0) && in_mem && !mem_ready &&
                    (({1'b0, wcnt} + (TO_W+1)'(1)) == TO_LIM);

    // R-type function decode: legality and the ALU operation it selects.
    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case (func)
            6'h20:   r_alu = ALU_ADD;
            6'h22:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h27:   r_alu = ALU_NOR;
            6'h2A:   r_alu = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        st_nxt = st;
        case (st)
            FETCH:    if (mem_ready) st_nxt = DECODE;
                      else if (to_hit) st_nxt = HALT;
            DECODE: begin
                case (op)
                    6'h00:        st_nxt = r_legal ? R_EXEC : HALT;
                    6'h23, 6'h2B: st_nxt = MEM_ADDR;
                    6'h04, 6'h05: st_nxt = BRANCH;
                    6'h08:        st_nxt = I_EXEC;
                    6'h02:        st_nxt = JUMP;
                    default:      st_nxt = HALT;
                endcase
            end
            MEM_ADDR: st_nxt = (op == 6'h23) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) st_nxt = MEM_WB;
                      else if (to_hit) st_nxt = HALT;
            MEM_WB:   st_nxt = FETCH;
            MEM_WR:   if (mem_ready) st_nxt = FETCH;
                      else if (to_hit) st_nxt = HALT;
            R_EXEC:   st_nxt = R_WB;
            R_WB:     st_nxt = FETCH;
            BRANCH:   st_nxt = FETCH;
            I_EXEC:   st_nxt = I_WB;
            I_WB:     st_nxt = FETCH;
            JUMP:     st_nxt = FETCH;
            default:  st_nxt = HALT;
        endcase
    end

    // Datapath strobes per state; everything is held low while in reset.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_cntl   = 4'b0000;
        pc_src     = 2'b00;
        case (st)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_cntl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_cntl  = ALU_ADD;
            end
            MEM_ADDR, I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_cntl  = ALU_ADD;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_cntl  = r_alu;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_cntl  = r_alu;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_cntl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = (op == 6'h04) ? zero : !zero;
            end
            I_WB:    reg_write = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_cntl   = 4'b0000;
            pc_src     = 2'b00;
        end
    end

    // State, wait counter, sticky timeout flag and retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st      <= FETCH;
            wcnt    <= '0;
            timeout <= 1'b0;
            retired <= '0;
        end else begin
            st <= st_nxt;
            if (st_nxt != st)
                wcnt <= '0;
            else if (in_mem && !mem_ready)
                wcnt <= wcnt + TO_W'(1);
            if (to_hit)
                timeout <= 1'b1;
            // Only final states lead back to FETCH.
            if (st_nxt == FETCH && st != FETCH)
                retired <= retired + CNT_W'(1);
        end
    end

    assign state  = st;
    assign halted = (st == HALT);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a multicycle MIPS datapath: one shared memory (instruction and data), an IR, an ALUOut register and a single ALU used for PC+4, branch target and execute.
- Replaces the single-cycle combinational control unit.
- Decodes op/func from the IR, drives every datapath strobe and mux select, and handshakes with memory through mem_ready.
- Counts retired instructions and halts on an illegal instruction or a memory timeout.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TO_W, 8, width of the memory-wait counter.
- TIMEOUT, 200, maximum cycles in one memory state without mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- zero  in  1  ALU Z flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable; already qualified with the branch condition.
- ir_write  out  1  IR load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_to_reg  out  1  register write data select: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_cntl  out  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- halted  out  1  controller is in HALT.
- timeout  out  1  HALT was caused by a memory timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: reset low forces state = FETCH, retired = 0, halted = 0, timeout = 0, wait counter = 0.
  - While reset is low, all strobes and selects are forced to 0.
  - The first fetch begins on the first clk edge after reset goes high.
  - Reset asserted mid-instruction aborts the instruction; it is not counted as retired.
- Defaults: every output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, I_EXEC 9, I_WB 10, JUMP 11, HALT 15.
- FETCH:
  - Drives mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, ADD, pc_src = 00.
  - ir_write and pc_write = mem_ready (Mealy).
  - Goes to DECODE when mem_ready = 1; otherwise stays.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 11, ADD (branch target into ALUOut).
  - op 0x00 -> R_EXEC if func is one of 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt; any other func -> HALT.
  - op 0x23 or 0x2B -> MEM_ADDR; 0x04 or 0x05 -> BRANCH; 0x08 -> I_EXEC; 0x02 -> JUMP; any other op -> HALT.
- MEM_ADDR: drives alu_src_a = 1, alu_src_b = 10, ADD. Goes to MEM_RD if op = 0x23, else MEM_WR.
- MEM_RD: drives iord = 1, mem_read = 1. Goes to MEM_WB on mem_ready.
- MEM_WB: drives reg_write = 1, mem_to_reg = 1, reg_dst = 0. Goes to FETCH and retires.
- MEM_WR: drives iord = 1, mem_write = 1. Goes to FETCH on mem_ready and retires.
- R_EXEC: drives alu_src_a = 1, alu_src_b = 00, alu_cntl decoded from func. Goes to R_WB.
- R_WB: drives reg_write = 1, reg_dst = 1, mem_to_reg = 0 (alu_cntl held). Goes to FETCH and retires.
- BRANCH:
  - Drives alu_src_a = 1, alu_src_b = 00, SUB, pc_src = 01.
  - pc_write = zero for op 0x04, ~zero for op 0x05.
  - Goes to FETCH and retires, whether or not the branch is taken.
- I_EXEC: drives alu_src_a = 1, alu_src_b = 10, ADD. Goes to I_WB.
- I_WB: drives reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH and retires.
- JUMP: drives pc_src = 10, pc_write = 1. Goes to FETCH and retires.
- HALT:
  - All strobes 0, halted = 1. Sticky until reset.
  - retired is not incremented on entry to HALT.
- Latency with zero-wait memory: R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3 cycles. Each mem_ready wait cycle adds one cycle.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR, and increments on each cycle in those states with mem_ready = 0.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT with mem_ready still 0: go to HALT, set timeout = 1.
  - mem_ready on the same cycle the limit is reached wins: normal transition, no timeout.
- Retire counter: `retired` increments on the clock edge that leaves a final state for FETCH and wraps modulo 2^CNT_W.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- zero is ignored outside BRANCH.

Test Plan:
- Reset low mid-MEM_RD, then release -> all strobes 0 during reset; state = 0, retired = 0; fetch resumes next cycle with mem_read = 1, iord = 0.
- add (op 0x00, func 0x20), mem_ready tied 1 -> states 0,1,6,7,0; alu_cntl = 0010 in R_EXEC; reg_write = 1 and reg_dst = 1 only in R_WB; retired 0 -> 1.
- lw with mem_ready low for 3 cycles in MEM_RD -> instruction takes 8 cycles; mem_to_reg = 1 and reg_write = 1 only in MEM_WB.
- beq with zero = 1, then bne with zero = 1 -> pc_write = 1 with pc_src = 01 in the first BRANCH; pc_write = 0 in the second; both retire (retired += 2).
- op 0x3F -> DECODE -> HALT; halted = 1, all strobes 0 for 10+ cycles; retired unchanged.
- TIMEOUT = 5, mem_ready held 0 in FETCH -> HALT after 5 wait cycles with timeout = 1. Repeat with mem_ready = 1 on the 5th cycle -> DECODE, timeout = 0.
